// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the prefetch queue entry layout.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; the head entry is held in a register so the
// read side is flop-driven and keeps its last value when the FIFO empties.
module ifq_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        head_nxt   = rd_data;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_en) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (pop)   rd_ptr_nxt = rd_ptr + PTR_ONE;
            // the next head is either the entry written right now or one already stored
            if (rd_ptr_nxt == wr_ptr) begin
                if (wr_en) head_nxt = wr_data;
            end else begin
                head_nxt = mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            rd_data <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit,
// buffers in-order responses with their PCs and squashes stale ones on redirect.
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_target;
    logic [CW-1:0]   inflight, drop;
    logic [AW:0]     fifo_count;
    logic            fifo_full, fifo_empty;
    logic [31:0]     credit_used;
    logic            req_fire, rsp_live;
    logic            unused_pc_bits;
    ifq_entry_t      wr_entry, head;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits  = ^redirect_pc[1:0];

    // Slots already promised: stored entries plus responses that will still land.
    assign credit_used = 32'(fifo_count) + 32'(inflight) - 32'(drop);

    assign req_valid = rst && !redirect_valid
                    && (32'(inflight) < 32'(MAX_OUTSTANDING))
                    && (credit_used < 32'(DEPTH));
    assign req_addr  = fetch_pc;
    assign req_fire  = req_valid && req_ready;
    assign rsp_live  = rsp_valid && !redirect_valid && (drop == '0);

    assign wr_entry.pc    = rsp_pc;
    assign wr_entry.instr = rsp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop     <= inflight - CW'(rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_live) rsp_pc   <= rsp_pc + PC_STEP;
                if (rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    ifq_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush   (redirect_valid),
        .wr_en   (rsp_live),
        .wr_data (wr_entry),
        .rd_en   (instr_ready),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_live && fifo_full && !instr_ready));
    a_inflight_cap: assert property (@(posedge clk) disable iff (!rst)
        32'(inflight) <= 32'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order memory responder and a PC model.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    typedef struct {
        logic [31:0] addr;
        longint      due;
    } pend_t;

    pend_t       pend[$];
    longint      cyc = 0;
    longint      last_due = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          nfire = 0;
    int          base;
    logic [31:0] exp_pc = '0;
    logic [31:0] last_addr = '0;

    always #5 clk = ~clk;

    ifetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then present the next response.
    task automatic tick();
        int     l;
        longint due;
        @(negedge clk);
        if (rsp_valid && pend.size() > 0) void'(pend.pop_front());
        if (rst && redirect_valid) begin
            chk("redirect_no_req", 32'(req_valid), 32'd0);
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (rst && instr_valid && instr_ready) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (req_valid && req_ready) begin
            l = rand_lat ? int'($urandom_range(1, 3)) : lat;
            due = cyc + longint'(l);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: req_addr, due: due});
            nfire++;
            last_addr = req_addr;
            chk("inflight_bound", 32'(pend.size() <= 2), 32'd1);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pend[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        pend.delete();
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        exp_pc = 32'd0;
    endtask

    initial begin
        // Power-on reset, then a streaming fetch at latency 1.
        tick();
        tick();
        chk("por_req_valid", 32'(req_valid), 32'd0);
        chk("por_instr_valid", 32'(instr_valid), 32'd0);
        chk("por_instr", instr, 32'd0);
        chk("por_instr_pc", instr_pc, 32'd0);
        rst = 1'b1;
        exp_pc = 32'd0;
        #1;
        chk("t1_c0_req_valid", 32'(req_valid), 32'd1);
        chk("t1_c0_addr", req_addr, 32'h0);
        tick();
        #1;
        chk("t1_c1_addr", req_addr, 32'h4);
        chk("t1_c1_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        #1;
        chk("t1_c2_instr_valid", 32'(instr_valid), 32'd1);
        chk("t1_c2_instr_pc", instr_pc, 32'h0);
        chk("t1_c2_instr", instr, mem_word(32'h0));
        chk("t1_c2_addr", req_addr, 32'h8);
        tick();
        #1;
        chk("t1_c3_addr", req_addr, 32'hC);
        repeat (4) tick();

        // Back-pressure: the queue fills to DEPTH and one pop frees one credit.
        do_reset();
        lat = 1;
        instr_ready = 1'b0;
        req_ready = 1'b1;
        base = nfire;
        repeat (8) tick();
        #1;
        chk("t2_fires_full", 32'(nfire - base), 32'd4);
        chk("t2_req_stalled", 32'(req_valid), 32'd0);
        chk("t2_head_valid", 32'(instr_valid), 32'd1);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("t2_credit_req", 32'(req_valid), 32'd1);
        chk("t2_credit_addr", req_addr, 32'h10);
        repeat (5) tick();
        #1;
        chk("t2_fires_after", 32'(nfire - base), 32'd5);
        chk("t2_req_stalled2", 32'(req_valid), 32'd0);
        chk("t2_head_pc2", instr_pc, 32'h4);

        // Redirect with two outstanding, coinciding with a response and a pop.
        do_reset();
        lat = 2;
        instr_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("t3_inflight_cap", 32'(req_valid), 32'd0);
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        instr_ready = 1'b1;
        #1;
        chk("t3_rsp_in_redirect", 32'(rsp_valid), 32'd1);
        chk("t3_head_before", instr_pc, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_flushed", 32'(instr_valid), 32'd0);
        chk("t3_drain_req", 32'(req_valid), 32'd1);
        chk("t3_new_addr", req_addr, 32'h100);
        tick();
        #1;
        chk("t3_next_addr", req_addr, 32'h104);
        chk("t3_still_empty", 32'(instr_valid), 32'd0);
        tick();
        tick();
        #1;
        chk("t3_first_valid", 32'(instr_valid), 32'd1);
        chk("t3_first_pc", instr_pc, 32'h100);
        chk("t3_first_instr", instr, mem_word(32'h100));

        // Random stalls and latencies against the PC model, then a full drain.
        rand_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            req_ready   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rand_lat = 1'b0;
        req_ready = 1'b0;
        instr_ready = 1'b1;
        repeat (10) tick();
        #1;
        chk("rand_drained", 32'(instr_valid), 32'd0);
        chk("rand_all_popped", exp_pc, last_addr + 32'd4);

        // Address wrap at the top of memory, then reset mid-stream.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        req_ready = 1'b1;
        lat = 1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_top", req_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        chk("wrap_addr_zero", req_addr, 32'h0);
        tick();
        #1;
        chk("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
        tick();
        do_reset();
        #1;
        chk("rst2_req_valid", 32'(req_valid), 32'd1);
        chk("rst2_addr", req_addr, 32'h0);
        chk("rst2_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        #1;
        chk("rst2_addr_next", req_addr, 32'h4);
        tick();
        #1;
        chk("rst2_head_valid", 32'(instr_valid), 32'd1);
        chk("rst2_head_pc", instr_pc, 32'h0);
        req_ready = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch queue that sits directly upstream of the IF/ID pipeline register and replaces the direct instruction-cache read in the fetch stage.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions together with their PCs in a FIFO and presents them to IF/ID with a valid/ready handshake.
- On a branch/jump redirect, flushes the FIFO and discards every response that is still in flight.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- MAX_OUTSTANDING, 2: maximum number of unanswered memory requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- redirect_valid  in  1  taken branch/jal/jalr redirect from the M stage
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0
- req_valid  out  1  instruction-memory request valid
- req_ready  in  1  memory accepts the request
- req_addr  out  32  word-aligned fetch address
- rsp_valid  in  1  response valid; always accepted; responses arrive in request order
- rsp_data  in  32  fetched instruction
- instr_valid  out  1  FIFO head is valid
- instr_ready  in  1  IF/ID consumes the head
- instr  out  32  head instruction
- instr_pc  out  32  PC of the head instruction

Behaviour:
- Reset (rst low, asynchronous) sets the following, and aborts any operation in progress, including in-flight requests:
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC
  - FIFO empty; inflight = 0; drop = 0
  - req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0
  - Responses arriving after reset release are counted only against post-reset requests. The memory side is reset together with this block.
- Request issue:
  - req_addr = fetch_pc.
  - req_valid = !redirect_valid && inflight < MAX_OUTSTANDING && (fifo_count + inflight - drop) < DEPTH.
  - req_fire = req_valid && req_ready; on req_fire, fetch_pc += 4 (wraps modulo 2^32) and inflight increments.
- Response handling:
  - On rsp_valid, inflight decrements.
  - If drop > 0 or redirect_valid is high in the same cycle, the response is discarded and drop decrements when drop > 0.
  - Otherwise {rsp_data, rsp_pc} is written to the FIFO tail and rsp_pc += 4.
  - The credit rule guarantees a live response never meets a full FIFO. Overflow is an assertion failure.
- Output side:
  - instr, instr_pc and instr_valid are registered from the FIFO head.
  - A response accepted in cycle N appears on the outputs at N+1 at the earliest; there is no bypass path.
  - A pop occurs when instr_valid && instr_ready.
  - When the FIFO is full, a pop and a write in the same cycle are both allowed.
  - When the FIFO is empty, instr_valid = 0 and instr/instr_pc hold their last value.
- Redirect (single cycle), taking effect the next cycle:
  - FIFO cleared, so instr_valid = 0 in the next cycle.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - drop = inflight - rsp_valid, i.e. every request outstanding after this cycle's response.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is ignored.
  - Back-to-back redirects are legal: drop is recomputed each cycle.
- Counter widths: inflight and drop are clog2(MAX_OUTSTANDING+1) bits; the FIFO pointers carry one extra wrap bit.
- State machine: IDLE/FETCH is implicit in the credit logic. drop > 0 defines the DRAIN condition, during which new requests are still allowed.

Decomposition:
- Shared package riscv_pkg holds XLEN = 32, INSTR_BYTES = 4 and RESET_PC_DEFAULT.
- One sub-module, ifq_fifo: a synchronous FIFO with a flush input, parameterized by width and depth, storing 64-bit {pc, instr} entries and providing count, full and empty.

Test Plan:
- Reset, with req_ready = 1 and memory latency 1: requests go to 0x0, 0x4, 0x8, 0xC. instr_valid rises 2 cycles after the first request with instr_pc = 0x0. The output sequence is in order with PCs incrementing by 4.
- Hold instr_ready = 0 with DEPTH = 4: exactly 4 requests issue, then req_valid stays 0. Raising instr_ready for one cycle allows exactly one further request.
- Redirect to 0x103 while 2 requests are outstanding: FIFO empty next cycle. The 2 stale responses are dropped. The next request address is 0x100 and the first output is instr_pc = 0x100.
- Redirect in the same cycle as rsp_valid and instr_ready: the response and the pop are both ignored, drop = inflight - 1, and req_valid = 0 that cycle.
- Random req_ready stalls and 1–3 cycle response latency against a reference PC model: no instruction lost or duplicated, no FIFO overflow, and inflight never exceeds MAX_OUTSTANDING.
- fetch_pc = 0xFFFF_FFFC: the next request wraps to 0x0. Assert rst mid-stream: all outputs return to reset values immediately and fetching restarts at RESET_PC.
